// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and sizes for the program-memory loader.
package pmem_pkg;
    localparam int PMEM_ADDR_W  = 8;
    localparam int PMEM_INSTR_W = 12;
    localparam int PMEM_DEPTH   = 256;
    typedef enum logic [2:0] {IDLE, S_CNT, S_LO, S_HI, S_CHK, DONE, ERR} pmem_state_t;
endpackage

// File: rtl/pmem_loader.sv
// pmem_loader: fills program memory from a byte stream, releases the core on a good checksum.
module pmem_loader
    import pmem_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = PMEM_ADDR_W,
    parameter int INSTR_W = PMEM_INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               LoadE,
    output logic [ADDR_W-1:0]  LoadAddr,
    output logic [INSTR_W-1:0] LoadInstruction,
    output logic               E,
    output logic               core_run,
    output logic               busy,
    output logic               done,
    output logic               error
);
    pmem_state_t        state, state_nx;
    logic [ADDR_W:0]    cnt, idx, idx_nx;
    logic [DATA_W-1:0]  lo, sum;
    logic               acc, can_start, match;
    always_comb begin
        state_nx  = state;
        in_ready  = state inside {S_CNT, S_LO, S_HI, S_CHK};
        acc       = in_valid && in_ready;
        can_start = start && (state inside {IDLE, DONE, ERR});
        idx_nx    = idx + (ADDR_W+1)'(1);
        match     = in_data == sum;
        case (state)
            IDLE, DONE, ERR: state_nx = can_start ? S_CNT : state;
            S_CNT:           state_nx = acc ? S_LO : state;
            S_LO:            state_nx = acc ? S_HI : state;
            S_HI:            state_nx = acc ? (idx_nx == cnt ? S_CHK : S_LO) : state;
            S_CHK:           state_nx = acc ? (match ? DONE : ERR) : state;
            default:         state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            LoadE           <= 1'b0;
            LoadAddr        <= '0;
            LoadInstruction <= '0;
            E               <= 1'b0;
            core_run        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            cnt             <= '0;
            idx             <= '0;
            sum             <= '0;
            lo              <= '0;
        end else begin
            state <= state_nx;
            LoadE <= 1'b0;
            if (can_start) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
                core_run <= 1'b0;
                E        <= 1'b0;
                idx      <= '0;
                sum      <= '0;
            end
            if (acc && state != S_CHK)
                sum <= sum ^ in_data;
            // a zero count means a full memory, hence the extra count bit
            if (acc && state == S_CNT)
                cnt <= in_data == '0 ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(in_data);
            if (acc && state == S_LO)
                lo <= in_data;
            if (acc && state == S_HI) begin
                LoadE           <= 1'b1;
                LoadAddr        <= idx[ADDR_W-1:0];
                LoadInstruction <= {in_data[INSTR_W-DATA_W-1:0], lo};
                idx             <= idx_nx;
            end
            if (acc && state == S_CHK) begin
                busy     <= 1'b0;
                done     <= match;
                error    <= !match;
                core_run <= match;
                E        <= match;
            end
        end
    end
endmodule
